rca_8_bit: RTL and testbench



---
 rtl/rca_8_bit_pkg.sv | 11 +
 rtl/rca_8_bit_if.sv | 26 ++
 rtl/rca_8_bit_full_adder.sv | 16 +
 rtl/rca_8_bit.sv | 42 ++++
 tb/tb_rca_8_bit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/rca_8_bit_pkg.sv
// Shared width constant and result payload for the 8-bit ripple-carry adder.
package rca_8_bit_pkg;

  localparam int unsigned ADDER_WIDTH = 8;

  typedef struct packed {
    logic                   carry;
    logic [ADDER_WIDTH-1:0] sum;
  } rca_result_t;

endpackage : rca_8_bit_pkg

// File: rtl/rca_8_bit_if.sv
// Operand/result bundle of the adder; master drives operands, slave returns the registered result.
interface rca_8_bit_if;

  logic [rca_8_bit_pkg::ADDER_WIDTH-1:0] x;
  logic [rca_8_bit_pkg::ADDER_WIDTH-1:0] y;
  logic                                  carry_in;
  logic [rca_8_bit_pkg::ADDER_WIDTH-1:0] sum;
  logic                                  carry_out;

  modport master (
    output x,
    output y,
    output carry_in,
    input  sum,
    input  carry_out
  );

  modport slave (
    input  x,
    input  y,
    input  carry_in,
    output sum,
    output carry_out
  );

endinterface : rca_8_bit_if

// File: rtl/rca_8_bit_full_adder.sv
// Purely combinational 1-bit full adder; one stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/rca_8_bit.sv
// 8-bit unsigned ripple-carry adder with a registered sum and carry-out.
module rca_8_bit
  import rca_8_bit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  rca_8_bit_if.slave  bus
);

  logic [ADDER_WIDTH:0]   c;
  logic [ADDER_WIDTH-1:0] s;
  rca_result_t            res_d;
  rca_result_t            res_q;

  assign c[0] = bus.carry_in;

  // Carry ripples strictly stage to stage; no lookahead.
  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (bus.x[i]),
      .b    (bus.y[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end

  assign res_d = '{carry: c[ADDER_WIDTH], sum: s};

  // Synchronous reset discards whatever operation is sampled on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign bus.sum       = res_q.sum;
  assign bus.carry_out = res_q.carry;

endmodule : rca_8_bit

// File: tb/tb_rca_8_bit.sv
// Directed self-checking bench for rca_8_bit with hand-computed expected results.
module tb_rca_8_bit;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  rca_8_bit_if bus ();

  rca_8_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands mid-cycle, then advance past the next rising edge.
  task automatic step(input logic [7:0] xv, input logic [7:0] yv,
                      input logic ci, input logic rn);
    @(negedge clk);
    bus.x        = xv;
    bus.y        = yv;
    bus.carry_in = ci;
    rst_n        = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    for (int i = 0; i < 2; i++) begin
      step(8'd200, 8'd100, 1'b0, 1'b0);
      got = {bus.carry_out, bus.sum};
      tests_run++;
      if (got !== 9'd0) begin
        tests_failed++;
        $display("FAIL reset_edge%0d got=%0d/%0d exp=0/0", i, got[7:0], got[8]);
      end
    end
    step(8'd200, 8'd100, 1'b0, 1'b1);
    got = {bus.carry_out, bus.sum};
    tests_run++;
    if (got !== {1'b1, 8'd44}) begin
      tests_failed++;
      $display("FAIL reset_release got=%0d/%0d exp=44/1", got[7:0], got[8]);
    end
  endtask

  task automatic test_no_carry();
    logic [7:0] xs [3] = '{8'd50, 8'd30, 8'd40};
    logic [7:0] ys [3] = '{8'd100, 8'd20, 8'd100};
    logic [8:0] ex [3] = '{9'd150, 9'd50, 9'd140};
    logic [8:0] got;
    for (int i = 0; i < 3; i++) begin
      step(xs[i], ys[i], 1'b0, 1'b1);
      got = {bus.carry_out, bus.sum};
      tests_run++;
      if (got !== ex[i]) begin
        tests_failed++;
        $display("FAIL no_carry%0d got=%0d exp=%0d", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [8:0] got;
    step(8'd50, 8'd100, 1'b0, 1'b1);
    @(negedge clk);
    bus.x        = 8'd1;
    bus.y        = 8'd2;
    bus.carry_in = 1'b0;
    #1;
    got = {bus.carry_out, bus.sum};
    tests_run++;
    if (got !== 9'd150) begin
      tests_failed++;
      $display("FAIL hold_between_edges got=%0d exp=150", got);
    end
    @(posedge clk);
    #1;
    got = {bus.carry_out, bus.sum};
    tests_run++;
    if (got !== 9'd3) begin
      tests_failed++;
      $display("FAIL hold_next_edge got=%0d exp=3", got);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] got;
    step(8'd250, 8'd40, 1'b0, 1'b1);
    got = {bus.carry_out, bus.sum};
    tests_run++;
    if (got !== {1'b1, 8'd34}) begin
      tests_failed++;
      $display("FAIL wrap got=%0d/%0d exp=34/1", got[7:0], got[8]);
    end
  endtask

  task automatic test_carry_in();
    logic [7:0] xs [3] = '{8'd100, 8'd150, 8'd255};
    logic [7:0] ys [3] = '{8'd150, 8'd103, 8'd0};
    logic [8:0] ex [3] = '{9'd251, 9'd254, 9'd256};
    logic [8:0] got;
    for (int i = 0; i < 3; i++) begin
      step(xs[i], ys[i], 1'b1, 1'b1);
      got = {bus.carry_out, bus.sum};
      tests_run++;
      if (got !== ex[i]) begin
        tests_failed++;
        $display("FAIL carry_in%0d got=%0d/%0d exp=%0d/%0d",
                 i, got[7:0], got[8], ex[i][7:0], ex[i][8]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs [5] = '{8'd255, 8'd0, 8'd1, 8'd128, 8'd85};
    logic [7:0] ys [5] = '{8'd255, 8'd0, 8'd1, 8'd128, 8'd170};
    logic       cs [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [8:0] ex [5] = '{9'd511, 9'd0, 9'd2, 9'd256, 9'd256};
    logic [8:0] got;
    for (int i = 0; i < 5; i++) begin
      step(xs[i], ys[i], cs[i], 1'b1);
      got = {bus.carry_out, bus.sum};
      tests_run++;
      if (got !== ex[i]) begin
        tests_failed++;
        $display("FAIL back_to_back%0d got=%0d/%0d exp=%0d/%0d",
                 i, got[7:0], got[8], ex[i][7:0], ex[i][8]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic       rs [3] = '{1'b1, 1'b0, 1'b1};
    logic [8:0] ex [3] = '{9'd511, 9'd0, 9'd511};
    logic [8:0] got;
    for (int i = 0; i < 3; i++) begin
      step(8'd255, 8'd255, 1'b1, rs[i]);
      got = {bus.carry_out, bus.sum};
      tests_run++;
      if (got !== ex[i]) begin
        tests_failed++;
        $display("FAIL midstream_reset%0d got=%0d/%0d exp=%0d/%0d",
                 i, got[7:0], got[8], ex[i][7:0], ex[i][8]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.carry_in = 1'b0;
    test_reset();
    test_no_carry();
    test_hold();
    test_wrap();
    test_carry_in();
    test_back_to_back();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_rca_8_bit
